// File: rtl/dram_stream_reader_if.sv
// Bundle for the burst-reader's command, RAM read port and output stream.
// master is the reader's view; slave is the command source, RAM and sink.
interface dram_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_q, out_ready,
    output cmd_ready, ram_re, ram_raddr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_q, out_ready,
    input  cmd_ready, ram_re, ram_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dram_stream_reader.sv
// Burst reader for a block RAM with one-cycle read latency; hides the latency
// behind a two-entry first-word-fall-through buffer feeding a valid/ready stream.
module dram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  dram_stream_reader_if.master bus,
  output logic                 busy,
  output logic                 done
);
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  cmd_ready_q;
  logic                  pend;
  logic                  pend_last;
  logic                  head_valid;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  skid_valid;
  logic                  skid_last;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop;
  logic                  accept;
  logic                  issue;
  logic [2:0]            used;

  assign pop    = head_valid && bus.out_ready;
  assign accept = bus.cmd_valid && cmd_ready_q;
  assign used   = 3'(head_valid) + 3'(skid_valid) + 3'(pend);

  // Read enable is qualified by this cycle's pop so the two-entry buffer
  // sustains one word per cycle and can never be overrun by returning data.
  assign issue = (state == READ) && (used < (3'(2) + 3'(pop)));

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.ram_re    = issue;
  assign bus.ram_raddr = raddr;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.out_last  = head_last;

  // Burst sequencing: command latch, address/count walk, completion pulse.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state       <= IDLE;
      raddr       <= '0;
      remaining   <= '0;
      cmd_ready_q <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
    end else begin
      done      <= 1'b0;
      pend      <= issue;
      pend_last <= issue && (remaining == CNT_WIDTH'(1));
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= READ;
            cmd_ready_q <= 1'b0;
            busy        <= 1'b1;
            raddr       <= bus.cmd_addr;
            remaining   <= (bus.cmd_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                               : {1'b0, bus.cmd_len};
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            raddr     <= raddr + ADDR_WIDTH'(1);
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pend && !skid_valid && (!head_valid || pop)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: head drives the stream, skid catches data while head stalls.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (!head_valid || pop) begin
      if (skid_valid) begin
        head_valid <= 1'b1;
        head_data  <= skid_data;
        head_last  <= skid_last;
        skid_valid <= pend;
        skid_data  <= bus.ram_q;
        skid_last  <= pend_last;
      end else begin
        head_valid <= pend;
        head_last  <= pend_last;
        if (pend) head_data <= bus.ram_q;
      end
    end else if (pend) begin
      skid_valid <= 1'b1;
      skid_data  <= bus.ram_q;
      skid_last  <= pend_last;
    end
  end
endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader: RAM model preloaded with i*0x0101,
// negedge monitor logging handshakes and reads, one task per scenario.
module tb_dram_stream_reader;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic r_clk = 1'b0;
  logic r_rst_n;
  logic busy;
  logic done;
  int   checks = 0;
  int   errors = 0;

  dram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 r_clk = ~r_clk;

  logic [DW-1:0] mem [256];
  always @(posedge r_clk) if (bus.ram_re) bus.ram_q <= mem[bus.ram_raddr];

  // Monitor state, appended at each falling edge
  int            cyc = 0;
  int            level = 0;
  int            stall_viol = 0;
  int            level_viol = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] hs_data [$];
  bit            hs_last [$];
  int            hs_cyc [$];
  logic [AW-1:0] iss_addr [$];
  int            acc_cyc [$];
  int            done_cyc [$];

  always @(negedge r_clk) begin
    cyc++;
    if (!r_rst_n) begin
      level      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        stall_viol++;
      if (level > 2) level_viol++;
      if (bus.out_valid && bus.out_ready) begin
        hs_data.push_back(bus.out_data);
        hs_last.push_back(bus.out_last);
        hs_cyc.push_back(cyc);
      end
      if (bus.ram_re) iss_addr.push_back(bus.ram_raddr);
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      level = level + (bus.ram_re ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Issue one command and run until done (or budget expires)
  task automatic run_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                           input bit toggle, input int budget, output bit ok);
    bit accepted = 1'b0;
    bit fin = 1'b0;
    @(posedge r_clk); #1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < budget && !fin; i++) begin
      bus.out_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      @(negedge r_clk);
      if (bus.cmd_valid && bus.cmd_ready) accepted = 1'b1;
      if (done) fin = 1'b1;
      @(posedge r_clk); #1;
      if (accepted) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    ok = fin;
  endtask

  task automatic test_reset();
    logic [29:0] got;
    #12;
    got = {bus.cmd_ready, bus.ram_re, bus.ram_raddr, bus.out_valid, bus.out_data,
           bus.out_last, busy, done};
    checks++;
    if (got !== 30'h2000_0000) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, 30'h2000_0000);
    end
    @(negedge r_clk);
    r_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_w [4];
    int h0, d0;
    bit ok;
    exp_w = '{16'h1010, 16'h1111, 16'h1212, 16'h1313};
    h0 = hs_data.size();
    d0 = done_cyc.size();
    run_burst(8'h10, 8'd4, 1'b0, 40, ok);
    repeat (3) @(posedge r_clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: done not seen within budget"); end
    checks++;
    if (hs_data.size() - h0 != 4) begin
      errors++; $display("FAIL basic_count: got %0d words expected 4", hs_data.size() - h0);
    end
    for (int i = 0; i < 4; i++) begin
      if (h0 + i < hs_data.size()) begin
        checks++;
        if (hs_data[h0+i] !== exp_w[i] || hs_last[h0+i] !== (i == 3)) begin
          errors++;
          $display("FAIL basic_word[%0d]: got %h last=%0b expected %h last=%0b",
                   i, hs_data[h0+i], hs_last[h0+i], exp_w[i], (i == 3));
        end
      end
    end
    if (h0 + 3 < hs_cyc.size()) begin
      checks++;
      if (hs_cyc[h0+3] - hs_cyc[h0] != 3) begin
        errors++; $display("FAIL basic_spacing: got %0d cycles expected 3", hs_cyc[h0+3] - hs_cyc[h0]);
      end
    end
    checks++;
    if (done_cyc.size() - d0 != 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cyc.size() - d0);
    end
    checks++;
    if (busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle: got busy=%b cmd_ready=%b expected 0 1", busy, bus.cmd_ready);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] exp_w [4];
    int h0, s0, l0;
    bit ok;
    exp_w = '{16'h1010, 16'h1111, 16'h1212, 16'h1313};
    h0 = hs_data.size();
    s0 = stall_viol;
    l0 = level_viol;
    run_burst(8'h10, 8'd4, 1'b1, 80, ok);
    checks++;
    if (!ok || hs_data.size() - h0 != 4) begin
      errors++; $display("FAIL stall_count: got %0d words ok=%0b expected 4 ok=1", hs_data.size() - h0, ok);
    end
    for (int i = 0; i < 4; i++) begin
      if (h0 + i < hs_data.size()) begin
        checks++;
        if (hs_data[h0+i] !== exp_w[i] || hs_last[h0+i] !== (i == 3)) begin
          errors++;
          $display("FAIL stall_word[%0d]: got %h last=%0b expected %h last=%0b",
                   i, hs_data[h0+i], hs_last[h0+i], exp_w[i], (i == 3));
        end
      end
    end
    checks++;
    if (stall_viol != s0) begin
      errors++; $display("FAIL stall_stability: got %0d unstable cycles expected 0", stall_viol - s0);
    end
    checks++;
    if (level_viol != l0) begin
      errors++; $display("FAIL stall_outstanding: got %0d cycles above 2 expected 0", level_viol - l0);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_w [4];
    int h0, i0;
    bit ok;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_w = '{16'hFEFE, 16'hFFFF, 16'h0000, 16'h0101};
    h0 = hs_data.size();
    i0 = iss_addr.size();
    run_burst(8'hFE, 8'd4, 1'b0, 40, ok);
    checks++;
    if (!ok || iss_addr.size() - i0 != 4 || hs_data.size() - h0 != 4) begin
      errors++;
      $display("FAIL wrap_count: got reads=%0d words=%0d ok=%0b expected 4 4 1",
               iss_addr.size() - i0, hs_data.size() - h0, ok);
    end
    for (int i = 0; i < 4; i++) begin
      if (i0 + i < iss_addr.size() && h0 + i < hs_data.size()) begin
        checks++;
        if (iss_addr[i0+i] !== exp_a[i] || hs_data[h0+i] !== exp_w[i]) begin
          errors++;
          $display("FAIL wrap_step[%0d]: got addr %h data %h expected addr %h data %h",
                   i, iss_addr[i0+i], hs_data[h0+i], exp_a[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    int h0, i0, a0, n_last, first_k, last_k;
    bit ok;
    h0 = hs_data.size();
    i0 = iss_addr.size();
    a0 = acc_cyc.size();
    run_burst(8'h00, 8'd0, 1'b0, 400, ok);
    checks++;
    if (!ok || hs_data.size() - h0 != 256 || iss_addr.size() - i0 != 256) begin
      errors++;
      $display("FAIL full_count: got words=%0d reads=%0d ok=%0b expected 256 256 1",
               hs_data.size() - h0, iss_addr.size() - i0, ok);
    end else begin
      n_last = 0;
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (hs_data[h0+i] !== {8'(i), 8'(i)} || iss_addr[i0+i] !== 8'(i)) begin
          errors++;
          $display("FAIL full_word[%0d]: got data %h addr %h expected %h %h",
                   i, hs_data[h0+i], iss_addr[i0+i], {8'(i), 8'(i)}, 8'(i));
        end
        if (hs_last[h0+i]) n_last++;
      end
      checks++;
      if (n_last != 1 || hs_last[h0+255] !== 1'b1) begin
        errors++; $display("FAIL full_last: got %0d last flags, final=%0b expected 1 1", n_last, hs_last[h0+255]);
      end
      first_k = hs_cyc[h0] - acc_cyc[a0] - 1;
      last_k  = hs_cyc[h0+255] - acc_cyc[a0] - 1;
      checks++;
      if (first_k != 2 || last_k != 257) begin
        errors++; $display("FAIL full_timing: got first=%0d last=%0d expected 2 257", first_k, last_k);
      end
    end
  endtask

  task automatic test_single_busy();
    logic [DW-1:0] exp_w [3];
    logic [AW-1:0] exp_a [3];
    bit            exp_l [3];
    int a0, h0, i0, d0;
    int n_acc = 0;
    int n_done = 0;
    exp_w = '{16'h4242, 16'h2020, 16'h2121};
    exp_a = '{8'h42, 8'h20, 8'h21};
    exp_l = '{1'b1, 1'b0, 1'b1};
    a0 = acc_cyc.size();
    h0 = hs_data.size();
    i0 = iss_addr.size();
    d0 = done_cyc.size();
    @(posedge r_clk); #1;
    bus.cmd_addr  = 8'h42;
    bus.cmd_len   = 8'd1;
    bus.cmd_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && n_done < 2; i++) begin
      @(negedge r_clk);
      if (bus.cmd_valid && bus.cmd_ready) n_acc++;
      if (done) n_done++;
      @(posedge r_clk); #1;
      if (n_acc == 1) begin
        bus.cmd_addr = 8'h20;
        bus.cmd_len  = 8'd2;
      end else if (n_acc >= 2) begin
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (n_done != 2 || acc_cyc.size() - a0 != 2) begin
      errors++; $display("FAIL busy_cmds: got done=%0d accepts=%0d expected 2 2", n_done, acc_cyc.size() - a0);
    end else begin
      checks++;
      if (acc_cyc[a0+1] != done_cyc[d0] + 1) begin
        errors++;
        $display("FAIL busy_accept_cycle: got %0d expected %0d", acc_cyc[a0+1], done_cyc[d0] + 1);
      end
    end
    checks++;
    if (hs_data.size() - h0 != 3 || iss_addr.size() - i0 != 3) begin
      errors++;
      $display("FAIL busy_count: got words=%0d reads=%0d expected 3 3", hs_data.size() - h0, iss_addr.size() - i0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hs_data[h0+i] !== exp_w[i] || hs_last[h0+i] !== exp_l[i] || iss_addr[i0+i] !== exp_a[i]) begin
          errors++;
          $display("FAIL busy_word[%0d]: got %h last=%0b addr %h expected %h last=%0b addr %h",
                   i, hs_data[h0+i], hs_last[h0+i], iss_addr[i0+i], exp_w[i], exp_l[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_w [3];
    logic [29:0]   got;
    int  seen = 0;
    bit  acc = 1'b0;
    int  h0, i0, d0;
    bit  ok;
    exp_w = '{16'h5050, 16'h5151, 16'h5252};
    @(posedge r_clk); #1;
    bus.cmd_addr  = 8'h30;
    bus.cmd_len   = 8'd8;
    bus.cmd_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && seen < 2; i++) begin
      @(negedge r_clk);
      if (bus.cmd_valid && bus.cmd_ready) acc = 1'b1;
      if (bus.out_valid && bus.out_ready) seen++;
      @(posedge r_clk); #1;
      if (acc) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (seen != 2) begin errors++; $display("FAIL rstmid_progress: got %0d words expected 2", seen); end
    #2;
    r_rst_n = 1'b0;
    #1;
    got = {bus.cmd_ready, bus.ram_re, bus.ram_raddr, bus.out_valid, bus.out_data,
           bus.out_last, busy, done};
    checks++;
    if (got !== 30'h2000_0000) begin
      errors++; $display("FAIL rstmid_async_values: got %h expected %h", got, 30'h2000_0000);
    end
    h0 = hs_data.size();
    i0 = iss_addr.size();
    d0 = done_cyc.size();
    @(negedge r_clk);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    repeat (6) @(negedge r_clk);
    @(posedge r_clk); #1;
    checks++;
    if (hs_data.size() != h0 || iss_addr.size() != i0 || done_cyc.size() != d0) begin
      errors++;
      $display("FAIL rstmid_stale: got words=%0d reads=%0d dones=%0d after reset expected 0 0 0",
               hs_data.size() - h0, iss_addr.size() - i0, done_cyc.size() - d0);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got cmd_ready=%b busy=%b expected 1 0", bus.cmd_ready, busy);
    end
    h0 = hs_data.size();
    run_burst(8'h50, 8'd3, 1'b0, 40, ok);
    checks++;
    if (!ok || hs_data.size() - h0 != 3) begin
      errors++; $display("FAIL rstmid_rerun_count: got %0d words ok=%0b expected 3 1", hs_data.size() - h0, ok);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hs_data[h0+i] !== exp_w[i] || hs_last[h0+i] !== (i == 2)) begin
          errors++;
          $display("FAIL rstmid_rerun_word[%0d]: got %h last=%0b expected %h last=%0b",
                   i, hs_data[h0+i], hs_last[h0+i], exp_w[i], (i == 2));
        end
      end
    end
  endtask

  initial begin
    r_rst_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i)};
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_full();
    test_single_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
